// File: rtl/qupls_cache_tag_lookup.sv
// Set-associative tag store with same-cycle hit/way lookup for the Qupls I-cache.
// Optional physical-tag snoop invalidate is built when QUPLS_CACHE_SNOOP_EN is defined.
module qupls_cache_tag_lookup #(
  parameter int unsigned AWID   = 32,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned LINES  = 64,
  parameter int unsigned LOBIT  = 7,
  parameter int unsigned HIBIT  = $clog2(LINES) - 1 + LOBIT,
  parameter int unsigned TAGBIT = HIBIT + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [$clog2(WAYS)-1:0]    wway,
  input  logic [AWID-1:0]            vadr_i,
  input  logic [AWID-1:0]            padr_i,
  input  logic [HIBIT-LOBIT:0]       ndx,
  input  logic [AWID-1:0]            adr,
  output logic                       hit,
  output logic [$clog2(WAYS)-1:0]    rway,
  output logic                       cv,
  input  logic                       inv_line,
  input  logic                       inv_all,
  input  logic [AWID-1:0]            inv_adr,
  input  logic                       snoop_v,
  input  logic [AWID-1:0]            snoop_adr
);

  localparam int unsigned TW = AWID - TAGBIT;
  localparam int unsigned NW = HIBIT - LOBIT + 1;
  localparam int unsigned WW = $clog2(WAYS);

  logic [LINES-1:0] valid_q [WAYS];
  logic [LINES-1:0] valid_d [WAYS];
  logic [TW-1:0]    vtag_q  [WAYS][LINES];
  logic [WAYS-1:0]  match_c;

  logic [NW-1:0] fill_ndx;
  logic [NW-1:0] inv_ndx;
  logic [TW-1:0] adr_tag;

  assign fill_ndx = vadr_i[HIBIT:LOBIT];
  assign inv_ndx  = inv_adr[HIBIT:LOBIT];
  assign adr_tag  = adr[AWID-1:TAGBIT];

`ifdef QUPLS_CACHE_SNOOP_EN
  logic [TW-1:0]   ptag_q [WAYS][LINES];
  logic [WAYS-1:0] snoop_hit_c;
  logic [NW-1:0]   snoop_ndx;
  logic [TW-1:0]   snoop_tag;

  assign snoop_ndx = snoop_adr[HIBIT:LOBIT];
  assign snoop_tag = snoop_adr[AWID-1:TAGBIT];

  // Physical tag write on fill (not reset)
  always_ff @(posedge clk) begin
    if (wr) ptag_q[wway][fill_ndx] <= padr_i[AWID-1:TAGBIT];
  end

  // Snoop compare against pre-edge valid/ptag of the snooped set
  always_comb begin
    snoop_hit_c = '0;
    for (int w = 0; w < int'(WAYS); w++)
      snoop_hit_c[w] = snoop_v && valid_q[w][snoop_ndx] &&
                       (ptag_q[w][snoop_ndx] == snoop_tag);
  end

  logic unused_bits;
  assign unused_bits = ^{vadr_i[LOBIT-1:0], vadr_i[TAGBIT-1:HIBIT+1],
                         adr[TAGBIT-1:0], inv_adr[AWID-1:HIBIT+1],
                         inv_adr[LOBIT-1:0], padr_i[TAGBIT-1:0],
                         snoop_adr[LOBIT-1:0], snoop_adr[TAGBIT-1:HIBIT+1]};
`else
  logic unused_bits;
  assign unused_bits = ^{vadr_i[LOBIT-1:0], vadr_i[TAGBIT-1:HIBIT+1],
                         adr[TAGBIT-1:0], inv_adr[AWID-1:HIBIT+1],
                         inv_adr[LOBIT-1:0], padr_i, snoop_v, snoop_adr};
`endif

  // Virtual tag write on fill (not reset)
  always_ff @(posedge clk) begin
    if (wr) vtag_q[wway][fill_ndx] <= vadr_i[AWID-1:TAGBIT];
  end

  // Per-way match at the lookup set
  always_comb begin
    match_c = '0;
    for (int w = 0; w < int'(WAYS); w++)
      match_c[w] = valid_q[w][ndx] && (vtag_q[w][ndx] == adr_tag);
  end

  // Hit and lowest matching way; scanning downward lets the lowest way win
  always_comb begin
    hit  = 1'b0;
    rway = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (match_c[w]) begin
        hit  = 1'b1;
        rway = WW'(w);
      end
    end
  end

  // Valid next state: invalidates, then fill set, then snoop clear wins
  always_comb begin
    valid_d = valid_q;
    if (inv_all) begin
      for (int w = 0; w < int'(WAYS); w++) valid_d[w] = '0;
    end else if (inv_line) begin
      for (int w = 0; w < int'(WAYS); w++) valid_d[w][inv_ndx] = 1'b0;
    end
    if (wr) valid_d[wway][fill_ndx] = 1'b1;
`ifdef QUPLS_CACHE_SNOOP_EN
    for (int w = 0; w < int'(WAYS); w++)
      if (snoop_hit_c[w]) valid_d[w][snoop_ndx] = 1'b0;
`endif
  end

  // Valid bits and registered hit, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= '0;
      cv <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cv      <= hit;
    end
  end

endmodule

// File: tb/tb_qupls_cache_tag_lookup.sv
// Directed self-checking bench for qupls_cache_tag_lookup (default parameters).
module tb_qupls_cache_tag_lookup;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [1:0]  wway;
  logic [31:0] vadr_i, padr_i, adr, inv_adr, snoop_adr;
  logic [5:0]  ndx;
  logic        hit, cv, inv_line, inv_all, snoop_v;
  logic [1:0]  rway;

  int errors = 0;
  int checks = 0;

  qupls_cache_tag_lookup dut (
    .clk(clk), .rst(rst), .wr(wr), .wway(wway), .vadr_i(vadr_i),
    .padr_i(padr_i), .ndx(ndx), .adr(adr), .hit(hit), .rway(rway), .cv(cv),
    .inv_line(inv_line), .inv_all(inv_all), .inv_adr(inv_adr),
    .snoop_v(snoop_v), .snoop_adr(snoop_adr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set index is address bits [12:7]
  function automatic logic [5:0] set_of(input logic [31:0] a);
    return a[12:7];
  endfunction

  task automatic fill(input logic [1:0] w, input logic [31:0] va, input logic [31:0] pa);
    wr = 1'b1; wway = w; vadr_i = va; padr_i = pa;
    tick();
    wr = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] a,
                      input logic exp_hit, input logic [1:0] exp_way);
    ndx = set_of(a); adr = a;
    #1;
    chk({tag, ".hit"}, 32'(hit), 32'(exp_hit));
    chk({tag, ".rway"}, 32'(rway), 32'(exp_way));
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; wway = '0; vadr_i = '0; padr_i = '0;
    ndx = '0; adr = '0; inv_line = 1'b0; inv_all = 1'b0; inv_adr = '0;
    snoop_v = 1'b0; snoop_adr = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.cv", 32'(cv), 32'd0);
    rst = 1'b1;
    tick();
    look("reset", 32'h0001_2080, 1'b0, 2'd0);
    chk("reset.cv_after", 32'(cv), 32'd0);

    // Fill way 2 at set 0x01 tag 0x4; no bypass, cv lags one cycle
    wr = 1'b1; wway = 2'd2; vadr_i = 32'h0001_2080; padr_i = '0;
    look("fill.same_cycle", 32'h0001_2080, 1'b0, 2'd0);
    tick();
    wr = 1'b0;
    look("fill.lookup", 32'h0001_2080, 1'b1, 2'd2);
    chk("fill.cv_lag", 32'(cv), 32'd0);
    tick();
    chk("fill.cv", 32'(cv), 32'd1);
    look("fill.other_tag", 32'h0001_6080, 1'b0, 2'd0);
    tick();
    chk("fill.cv_miss", 32'(cv), 32'd0);

    // Duplicate tags at set 0x10: lowest way reported
    fill(2'd3, 32'h0001_C800, '0);
    look("dup.way3", 32'h0001_C800, 1'b1, 2'd3);
    fill(2'd1, 32'h0001_C800, '0);
    look("dup.way1", 32'h0001_C800, 1'b1, 2'd1);

    // Populate set 0x05 ways 1..3, then fill way 0 during inv_line of set 0x05
    fill(2'd1, 32'h0000_4280, '0);
    fill(2'd2, 32'h0000_8280, '0);
    fill(2'd3, 32'h0000_C280, '0);
    look("set5.w2", 32'h0000_8280, 1'b1, 2'd2);
    inv_line = 1'b1; inv_adr = 32'h0000_0280;
    fill(2'd0, 32'h0001_0280, '0);
    inv_line = 1'b0;
    look("coll.w0", 32'h0001_0280, 1'b1, 2'd0);
    look("coll.w1", 32'h0000_4280, 1'b0, 2'd0);
    look("coll.w2", 32'h0000_8280, 1'b0, 2'd0);
    look("coll.w3", 32'h0000_C280, 1'b0, 2'd0);
    look("coll.other_set", 32'h0001_C800, 1'b1, 2'd1);

    // inv_all clears everything
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    look("invall.a", 32'h0001_2080, 1'b0, 2'd0);
    look("invall.b", 32'h0001_C800, 1'b0, 2'd0);
    look("invall.c", 32'h0001_0280, 1'b0, 2'd0);

    // Snoop at set 0x02, physical tag of 0x8000_4100
    fill(2'd1, 32'h0000_4100, 32'h8000_4100);
    look("snoop.pre", 32'h0000_4100, 1'b1, 2'd1);
    snoop_v = 1'b1; snoop_adr = 32'h4000_4100;
    tick();
    snoop_v = 1'b0;
    look("snoop.other_tag", 32'h0000_4100, 1'b1, 2'd1);
    snoop_v = 1'b1; snoop_adr = 32'h8000_4100;
    tick();
    snoop_v = 1'b0;
`ifdef QUPLS_CACHE_SNOOP_EN
    look("snoop.match", 32'h0000_4100, 1'b0, 2'd0);
`else
    look("snoop.ignored", 32'h0000_4100, 1'b1, 2'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
